// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SPI-mode SD card responder.
//   - FSM state encoding (also exported on the debug state port)
//   - command index constants, R1 bit positions, token and filler bytes
//   - r1_byte(): builds an R1 response from the idle and illegal flags
package sd_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RX_CMD = 3'd1,
        ST_NCR    = 3'd2,
        ST_RESP   = 3'd3,
        ST_TOKEN  = 3'd4,
        ST_DATA   = 3'd5,
        ST_CRC    = 3'd6
    } sd_state_e;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD16 = 6'd16;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam int R1_IDLE_BIT    = 0;
    localparam int R1_ILLEGAL_BIT = 2;

    localparam logic [7:0] DATA_TOKEN = 8'hFE;
    localparam logic [7:0] FILL_BYTE  = 8'hFF;
    localparam logic [9:0] BLOCK_LAST = 10'd511;

    function automatic logic [7:0] r1_byte(input logic idle, input logic illegal);
        logic [7:0] r;
        r = 8'h00;
        r[R1_IDLE_BIT]    = idle;
        r[R1_ILLEGAL_BIT] = illegal;
        return r;
    endfunction

endpackage

// File: rtl/sd_spi_edge_sync.sv
// Brings the asynchronous SPI pins into the system clock domain.
// Ports:
//   clk_i        system clock
//   reset_ni     synchronous active-low reset
//   cs_i/sclk_i/mosi_i   raw SPI pins
//   cs_o/mosi_o          2-FF synchronised chip select and data
//   sclk_rise_o/sclk_fall_o  one-clk strobes on synchronised sclk edges
module sd_spi_edge_sync (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic cs_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic cs_o,
    output logic mosi_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o
);

    logic [1:0] cs_q;
    logic [1:0] mosi_q;
    logic [2:0] sclk_q;   // [2] is the previous synchronised value for edge detect

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            cs_q   <= 2'b11;
            mosi_q <= 2'b11;
            sclk_q <= 3'b000;
        end else begin
            cs_q   <= {cs_q[0], cs_i};
            mosi_q <= {mosi_q[0], mosi_i};
            sclk_q <= {sclk_q[1:0], sclk_i};
        end
    end

    assign cs_o        = cs_q[1];
    assign mosi_o      = mosi_q[1];
    assign sclk_rise_o =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall_o = ~sclk_q[1] &  sclk_q[2];

endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card emulator: receives 48-bit command frames, answers with
// R1/R3/R7 responses and serves CMD17 single-block reads from rd_data.
// Ports:
//   clk, reset            system clock, synchronous active-low reset
//   cs, sclk, mosi, miso  SPI mode 0 link (card side)
//   rd_addr, rd_idx       latched CMD17 argument and byte index being fetched
//   rd_data               block byte, valid 1 clk after rd_idx changes
//   init_done, state      card out of idle, FSM state for debug
//
// state     | meaning
// IDLE      | cs high, waiting for selection
// RX_CMD    | hunting for start bit / shifting a 48-bit command
// NCR       | sending NCR_BYTES filler bytes
// RESP      | sending R1 plus any extra response bytes
// TOKEN     | sending the start-block token
// DATA      | sending the 512 block bytes
// CRC       | sending two dummy CRC bytes
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int unsigned   NCR_BYTES   = 1,
    parameter int unsigned   ACMD41_BUSY = 2,
    parameter logic [31:0]   OCR_VALUE   = 32'hC0FF8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic [31:0] rd_addr,
    output logic [8:0]  rd_idx,
    input  logic [7:0]  rd_data,
    output logic        init_done,
    output logic [2:0]  state
);

    localparam logic [9:0] NCR_LAST = 10'(NCR_BYTES - 1);
    localparam logic [3:0] BUSY_MAX = 4'(ACMD41_BUSY);

    logic cs_s, mosi_s, sclk_rise, sclk_fall;

    sd_spi_edge_sync u_sync (
        .clk_i       (clk),
        .reset_ni    (reset),
        .cs_i        (cs),
        .sclk_i      (sclk),
        .mosi_i      (mosi),
        .cs_o        (cs_s),
        .mosi_o      (mosi_s),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall)
    );

    sd_state_e   state_q;
    logic        miso_q;
    logic        init_done_q;
    logic [31:0] rd_addr_q;
    logic [8:0]  rd_idx_q;
    logic [3:0]  busy_q;
    logic        app_cmd_q;
    logic [5:0]  rx_cnt_q;      // frame bits received so far
    logic [37:0] cmd_sr_q;      // frame bits 45:8 (index + argument)
    logic [2:0]  bit_cnt_q;     // 7 = next fall starts a new byte
    logic [9:0]  byte_cnt_q;
    logic [7:0]  cur_q;         // byte currently on miso
    logic [7:0]  r1_q;
    logic [31:0] resp_ext_q;    // extra response bytes, MSB byte first
    logic [2:0]  resp_last_q;   // index of last response byte (0 or 4)
    logic        is_read_q;

    // Command decode, evaluated from the shifted frame while the last bit arrives.
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        dec_init, dec_illegal, dec_read;
    logic [3:0]  dec_busy;
    logic [2:0]  dec_last;
    logic [31:0] dec_ext, dec_addr;
    logic [7:0]  dec_r1;

    assign cmd_idx = cmd_sr_q[37:32];
    assign cmd_arg = cmd_sr_q[31:0];

    always_comb begin
        dec_init    = init_done_q;
        dec_busy    = busy_q;
        dec_illegal = 1'b0;
        dec_read    = 1'b0;
        dec_last    = 3'd0;
        dec_ext     = 32'h0;
        dec_addr    = rd_addr_q;
        case (cmd_idx)
            CMD0: begin
                dec_init = 1'b0;
                dec_busy = 4'd0;
            end
            CMD8: begin
                dec_ext  = {16'h0000, 4'h0, cmd_arg[11:8], cmd_arg[7:0]};
                dec_last = 3'd4;
            end
            CMD16, CMD55: ;
            CMD41: begin
                if (!app_cmd_q)
                    dec_illegal = 1'b1;
                else if (busy_q < BUSY_MAX)
                    dec_busy = busy_q + 4'd1;
                else
                    dec_init = 1'b1;
            end
            CMD58: begin
                dec_ext  = OCR_VALUE;
                dec_last = 3'd4;
            end
            CMD17: begin
                if (init_done_q) begin
                    dec_addr = cmd_arg;
                    dec_read = 1'b1;
                end else begin
                    dec_illegal = 1'b1;   // 0x05: idle + illegal
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        dec_r1 = r1_byte(~dec_init, dec_illegal);
    end

    logic [7:0] tx_src;

    always_comb begin
        case (state_q)
            ST_RESP:  tx_src = (byte_cnt_q == 10'd0) ? r1_q : resp_ext_q[31:24];
            ST_TOKEN: tx_src = DATA_TOKEN;
            ST_DATA:  tx_src = rd_data;
            default:  tx_src = FILL_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            miso_q      <= 1'b1;
            init_done_q <= 1'b0;
            rd_addr_q   <= 32'h0;
            rd_idx_q    <= 9'd0;
            busy_q      <= 4'd0;
            app_cmd_q   <= 1'b0;
            rx_cnt_q    <= 6'd0;
            cmd_sr_q    <= 38'h0;
            bit_cnt_q   <= 3'd7;
            byte_cnt_q  <= 10'd0;
            cur_q       <= FILL_BYTE;
            r1_q        <= 8'h00;
            resp_ext_q  <= 32'h0;
            resp_last_q <= 3'd0;
            is_read_q   <= 1'b0;
        end else if (cs_s && state_q != ST_IDLE) begin
            state_q    <= ST_IDLE;
            miso_q     <= 1'b1;
            app_cmd_q  <= 1'b0;
            rx_cnt_q   <= 6'd0;
            bit_cnt_q  <= 3'd7;
            byte_cnt_q <= 10'd0;
            rd_idx_q   <= 9'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_q   <= 1'b1;
                    rx_cnt_q <= 6'd0;
                    if (!cs_s)
                        state_q <= ST_RX_CMD;
                end

                ST_RX_CMD: begin
                    // The last response bit is held until the host has clocked it in.
                    if (sclk_rise) begin
                        miso_q <= 1'b1;
                        if (rx_cnt_q == 6'd0) begin
                            if (!mosi_s)
                                rx_cnt_q <= 6'd1;
                        end else if (rx_cnt_q == 6'd1) begin
                            // transmission bit must be 1, else resume hunting
                            rx_cnt_q <= mosi_s ? 6'd2 : 6'd0;
                        end else if (rx_cnt_q == 6'd47) begin
                            init_done_q <= dec_init;
                            busy_q      <= dec_busy;
                            app_cmd_q   <= (cmd_idx == CMD55);
                            rd_addr_q   <= dec_addr;
                            r1_q        <= dec_r1;
                            resp_ext_q  <= dec_ext;
                            resp_last_q <= dec_last;
                            is_read_q   <= dec_read;
                            rx_cnt_q    <= 6'd0;
                            bit_cnt_q   <= 3'd7;
                            byte_cnt_q  <= 10'd0;
                            state_q     <= ST_NCR;
                        end else begin
                            if (rx_cnt_q <= 6'd39)
                                cmd_sr_q <= {cmd_sr_q[36:0], mosi_s};
                            rx_cnt_q <= rx_cnt_q + 6'd1;
                        end
                    end
                end

                ST_NCR, ST_RESP, ST_TOKEN, ST_DATA, ST_CRC: begin
                    if (sclk_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            miso_q    <= tx_src[7];
                            cur_q     <= tx_src;
                            bit_cnt_q <= 3'd6;
                        end else begin
                            miso_q    <= cur_q[bit_cnt_q];
                            bit_cnt_q <= bit_cnt_q - 3'd1;   // 0 wraps to 7
                            if (bit_cnt_q == 3'd0) begin
                                case (state_q)
                                    ST_NCR: begin
                                        if (byte_cnt_q == NCR_LAST) begin
                                            byte_cnt_q <= 10'd0;
                                            state_q    <= ST_RESP;
                                        end else begin
                                            byte_cnt_q <= byte_cnt_q + 10'd1;
                                        end
                                    end
                                    ST_RESP: begin
                                        if (byte_cnt_q == {7'd0, resp_last_q}) begin
                                            byte_cnt_q <= 10'd0;
                                            state_q    <= is_read_q ? ST_TOKEN : ST_RX_CMD;
                                        end else begin
                                            byte_cnt_q <= byte_cnt_q + 10'd1;
                                            if (byte_cnt_q != 10'd0)
                                                resp_ext_q <= {resp_ext_q[23:0], 8'h00};
                                        end
                                    end
                                    ST_TOKEN: begin
                                        byte_cnt_q <= 10'd0;
                                        state_q    <= ST_DATA;
                                    end
                                    ST_DATA: begin
                                        // 9-bit index wraps back to 0 after byte 511
                                        rd_idx_q <= rd_idx_q + 9'd1;
                                        if (byte_cnt_q == BLOCK_LAST) begin
                                            byte_cnt_q <= 10'd0;
                                            state_q    <= ST_CRC;
                                        end else begin
                                            byte_cnt_q <= byte_cnt_q + 10'd1;
                                        end
                                    end
                                    default: begin
                                        if (byte_cnt_q == 10'd1) begin
                                            byte_cnt_q <= 10'd0;
                                            state_q    <= ST_RX_CMD;
                                        end else begin
                                            byte_cnt_q <= byte_cnt_q + 10'd1;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign miso      = miso_q;
    assign rd_addr   = rd_addr_q;
    assign rd_idx    = rd_idx_q;
    assign init_done = init_done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
module tb_sd_spi_responder;

    localparam int          NCR  = 1;
    localparam int          BUSY = 2;
    localparam logic [31:0] OCR  = 32'hC0FF8000;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        cs    = 1'b1;
    logic        sclk  = 1'b0;
    logic        mosi  = 1'b1;
    logic        miso;
    logic [31:0] rd_addr;
    logic [8:0]  rd_idx;
    logic [7:0]  rd_data;
    logic        init_done;
    logic [2:0]  state;

    sd_spi_responder #(
        .NCR_BYTES   (NCR),
        .ACMD41_BUSY (BUSY),
        .OCR_VALUE   (OCR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .rd_addr   (rd_addr),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .init_done (init_done),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Block byte source: one clk of latency after rd_idx changes.
    logic [7:0] data_mask = 8'h00;
    always @(posedge clk) rd_data <= rd_idx[7:0] ^ data_mask;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference card model
    logic        m_init;
    int          m_busy;
    logic        m_app;
    logic [31:0] m_addr;
    logic [7:0]  exp_q[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // SPI mode 0 byte: 4 clk low, host samples miso as sclk rises, 3 clk high.
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            sclk = 1'b0;
            mosi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = miso;
            sclk  = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    // Builds the full byte stream the card should return after a command.
    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [7:0]  idle_r1;
        logic [31:0] ocr_v;
        ocr_v = OCR;
        exp_q.delete();
        repeat (NCR) exp_q.push_back(8'hFF);
        idle_r1 = {7'd0, !m_init};
        case (idx)
            6'd0: begin
                m_init = 1'b0;
                m_busy = 0;
                exp_q.push_back(8'h01);
            end
            6'd8: begin
                exp_q.push_back(idle_r1);
                exp_q.push_back(8'h00);
                exp_q.push_back(8'h00);
                exp_q.push_back({4'h0, arg[11:8]});
                exp_q.push_back(arg[7:0]);
            end
            6'd16, 6'd55: exp_q.push_back(idle_r1);
            6'd41: begin
                if (!m_app) begin
                    exp_q.push_back(8'h04 | idle_r1);
                end else if (m_busy < BUSY) begin
                    m_busy++;
                    exp_q.push_back(8'h01);
                end else begin
                    m_init = 1'b1;
                    exp_q.push_back(8'h00);
                end
            end
            6'd58: begin
                exp_q.push_back(idle_r1);
                for (int b = 3; b >= 0; b--) exp_q.push_back(ocr_v[8*b +: 8]);
            end
            6'd17: begin
                if (m_init) begin
                    m_addr = arg;
                    exp_q.push_back(8'h00);
                    exp_q.push_back(8'hFE);
                    for (int i = 0; i < 512; i++) exp_q.push_back(8'(i) ^ data_mask);
                    exp_q.push_back(8'hFF);
                    exp_q.push_back(8'hFF);
                end else begin
                    exp_q.push_back(8'h05);
                end
            end
            default: exp_q.push_back(8'h04 | idle_r1);
        endcase
        m_app = (idx == 6'd55);
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input int max_rx, input string tag);
        logic [47:0] f;
        logic [7:0]  rx;
        int          n;
        model_cmd(idx, arg);
        f = {2'b01, idx, arg, 8'h95};
        for (int b = 0; b < 6; b++) spi_byte(f[47-8*b -: 8], rx);
        n = (exp_q.size() < max_rx) ? exp_q.size() : max_rx;
        for (int k = 0; k < n; k++) begin
            spi_byte(8'hFF, rx);
            check($sformatf("%s byte%0d", tag, k), {24'h0, rx}, {24'h0, exp_q[k]});
        end
    endtask

    initial begin
        logic [5:0]  ridx;
        logic [31:0] rarg;
        int          sel;

        m_init = 1'b0;
        m_busy = 0;
        m_app  = 1'b0;
        m_addr = 32'h0;

        repeat (4) @(negedge clk);
        check("reset miso", {31'h0, miso}, 32'h1);
        check("reset state", {29'h0, state}, 32'h0);
        check("reset init_done", {31'h0, init_done}, 32'h0);
        check("reset rd_addr", rd_addr, 32'h0);
        check("reset rd_idx", {23'h0, rd_idx}, 32'h0);

        reset = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        check("select state", {29'h0, state}, 32'h1);

        run_cmd(6'd0, 32'h0, 64, "cmd0");
        check("state after cmd0", {29'h0, state}, 32'h1);

        run_cmd(6'd8, 32'h000001AA, 64, "cmd8");
        run_cmd(6'd8, $urandom, 64, "cmd8 rand");
        run_cmd(6'd17, 32'h00001000, 64, "cmd17 pre-init");
        check("state after cmd17 pre-init", {29'h0, state}, 32'h1);

        for (int r = 0; r < 3; r++) begin
            run_cmd(6'd55, 32'h0, 64, "cmd55");
            run_cmd(6'd41, 32'h40000000, 64, $sformatf("acmd41 #%0d", r));
            check($sformatf("init_done after acmd41 #%0d", r), {31'h0, init_done}, {31'h0, m_init});
        end

        run_cmd(6'd58, 32'h0, 64, "cmd58");

        data_mask = 8'h00;
        run_cmd(6'd17, 32'h00001000, 1000, "read");
        check("rd_addr after read", rd_addr, m_addr);
        check("state after read", {29'h0, state}, 32'h1);

        for (int r = 0; r < 6; r++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: run_cmd(6'd8, $urandom, 64, "rand cmd8");
                1: run_cmd(6'd16, $urandom, 64, "rand cmd16");
                2: run_cmd(6'd58, $urandom, 64, "rand cmd58");
                3: begin
                    run_cmd(6'd55, $urandom, 64, "rand cmd55");
                    run_cmd(6'd41, $urandom, 64, "rand acmd41");
                end
                4: begin
                    do ridx = 6'($urandom_range(0, 63));
                    while (ridx inside {6'd0, 6'd8, 6'd16, 6'd17, 6'd41, 6'd55, 6'd58});
                    run_cmd(ridx, $urandom, 64, $sformatf("rand illegal cmd%0d", ridx));
                end
                default: run_cmd(6'd41, $urandom, 64, "rand cmd41 no app");
            endcase
        end

        // Partial read aborted by cs
        data_mask = 8'($urandom);
        rarg      = $urandom | 32'h1;
        run_cmd(6'd17, rarg, NCR + 2 + 200, "partial read");
        @(negedge clk);
        cs    = 1'b1;
        sclk  = 1'b0;
        m_app = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort miso", {31'h0, miso}, 32'h1);
        check("abort state", {29'h0, state}, 32'h0);
        check("abort init_done", {31'h0, init_done}, {31'h0, m_init});
        check("abort rd_addr", rd_addr, m_addr);

        repeat (4) @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        check("reselect state", {29'h0, state}, 32'h1);
        check("init_done held", {31'h0, init_done}, 32'h1);
        run_cmd(6'd0, 32'h0, 64, "cmd0 after abort");
        check("init_done after cmd0", {31'h0, init_done}, 32'h0);

        // Reset in the middle of a CMD58 response (miso is driving 0 here)
        run_cmd(6'd58, 32'h0, NCR + 2, "cmd58 partial");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midreset state", {29'h0, state}, 32'h0);
        check("midreset miso", {31'h0, miso}, 32'h1);
        check("midreset rd_addr", rd_addr, 32'h0);
        check("midreset init_done", {31'h0, init_done}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- SPI-mode SD card emulator: the card side of the link driven by our SD controller.
- Samples cs/sclk/mosi with the system clock, decodes 48-bit command frames, and returns R1/R3/R7 responses on miso.
- Serves single-block reads (CMD17) from an external byte source.
- Used in simulation benches and on-board loopback in place of a physical card.

Parameters:
- NCR_BYTES, 1, number of 0xFF filler bytes between command end and response (1..8).
- ACMD41_BUSY, 2, number of ACMD41s answered 0x01 before init completes (0..15).
- OCR_VALUE, 32'hC0FF8000, OCR returned by CMD58.

Ports:
- clk  input  1  system clock; sclk must be at most clk/4.
- reset  input  1  synchronous, active-low reset.
- cs  input  1  SPI chip select, active low.
- sclk  input  1  SPI clock, mode 0.
- mosi  input  1  command/data from host.
- miso  output  1  response/data to host.
- rd_addr  output  32  latched CMD17 argument.
- rd_idx  output  9  byte index within block being fetched.
- rd_data  input  8  block byte; valid 1 clk after rd_idx changes.
- init_done  output  1  card has left idle state.
- state  output  3  FSM state, for LED/debug.

Behaviour:
- Synchronisation:
  - cs, sclk, mosi pass through 2-FF synchronisers; sclk edges are detected on the synchronised signal.
  - mosi is sampled on sclk rising edge; miso updates on sclk falling edge, MSB first.
- Reset (reset==0 at clk edge): state=IDLE, miso=1, init_done=0, rd_addr=0, rd_idx=0, busy counter=0, app_cmd flag=0.
- miso is 1 whenever cs=1 or no byte is being transmitted.
- FSM states, encoded 0..6:
  - IDLE(0): wait for cs=0, then go to RX_CMD.
  - RX_CMD(1): ignore 1 bits until the first 0 (start bit). Then shift 47 more bits (48 total). Bit 46 must be 1, otherwise discard and stay in RX_CMD. CRC7 and stop bit are ignored. At the 48th bit, decode and go to NCR.
  - NCR(2): transmit NCR_BYTES of 0xFF, byte-aligned to the end of the command, then go to RESP.
  - RESP(3): transmit R1, then any extra response bytes.
    - CMD17 with R1=0x00 → TOKEN.
    - Otherwise → RX_CMD.
  - TOKEN(4): transmit 0xFE → DATA.
  - DATA(5): transmit rd_data for rd_idx 0..511. rd_idx advances at the start of each byte's last bit, so data is ready 1 clk later. After byte 511 → CRC.
  - CRC(6): transmit 0xFF, 0xFF → RX_CMD; rd_idx returns to 0.
- R1 encoding:
  - bit0 = ~init_done.
  - bit2 = illegal command.
  - All other bits 0.
- Command decode (index = bits 45:40, arg = bits 39:8):
  - CMD0: init_done=0, busy counter=0; R1=0x01.
  - CMD8: R1 followed by {0x00, 0x00, 0x0, arg[11:8], arg[7:0]}.
  - CMD55: R1; sets app_cmd for the next command only.
  - ACMD41 (CMD41 with app_cmd=1):
    - busy counter < ACMD41_BUSY: increment counter, R1=0x01.
    - otherwise: init_done=1, R1=0x00.
  - CMD41 without app_cmd: illegal.
  - CMD58: R1 followed by OCR_VALUE, MSB first.
  - CMD16: R1 only; argument ignored.
  - CMD17 when init_done=1: rd_addr=arg; R1=0x00; block follows.
  - CMD17 when init_done=0: R1=0x05 and no data.
  - Any other index: R1 = 0x04 | ~init_done.
- app_cmd clears after any command other than CMD55.
- Bits on mosi during NCR/RESP/TOKEN/DATA/CRC are ignored; there is no CMD12 support.
- cs rising mid-operation (any state): abort to IDLE at the next clk. Shift and bit counters clear and miso=1. init_done, busy counter and rd_addr are preserved; app_cmd clears.
- cs falling again resumes in RX_CMD hunting for a start bit.
- A reset asserted mid-transfer takes priority over all events.

Decomposition:
- Shared package sd_spi_pkg:
  - FSM state encoding.
  - Command index constants (CMD0, 8, 16, 17, 41, 55, 58).
  - R1 bit positions and token value 0xFE.
- One natural sub-module, sd_spi_edge_sync: 2-FF synchronisers plus sclk rise/fall strobes. The FSM, shifters and decoder live in the top.

Test Plan:
- CMD0 frame 40 00 00 00 00 95 → after 1 filler 0xFF, miso byte 0x01; state returns to 1.
- CMD8 arg 0x000001AA → 0x01 then 00 00 01 AA.
- CMD55+ACMD41 three times with ACMD41_BUSY=2 → R1 sequence 01, 01, 00 to the ACMD41s; init_done=1 after the third.
- CMD58 → 00 C0 FF 80 00; CMD17 before init → 0x05 with no token.
- CMD17 arg 0x00001000 after init, rd_data = rd_idx[7:0] → rd_addr=0x1000, then R1 00, FE, 00 01 … FF 00 … FF (512 bytes), FF FF.
- cs deasserted after 200 data bytes → miso=1 and state=0 within 3 clk. Next CMD0 still answered correctly; init_done is held until that CMD0 clears it.
